// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic round-robin arbiter, one transfer per grant.
// Optional grant timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_wb_adr_i,
    input  logic [DATA_W-1:0]   m0_wb_dat_i,
    output logic [DATA_W-1:0]   m0_wb_dat_o,
    input  logic                m0_wb_we_i,
    input  logic [DATA_W/8-1:0] m0_wb_sel_i,
    input  logic                m0_wb_stb_i,
    output logic                m0_wb_ack_o,
    output logic                m0_wb_err_o,
    input  logic [ADDR_W-1:0]   m1_wb_adr_i,
    input  logic [DATA_W-1:0]   m1_wb_dat_i,
    output logic [DATA_W-1:0]   m1_wb_dat_o,
    input  logic                m1_wb_we_i,
    input  logic [DATA_W/8-1:0] m1_wb_sel_i,
    input  logic                m1_wb_stb_i,
    output logic                m1_wb_ack_o,
    output logic                m1_wb_err_o,
    output logic [ADDR_W-1:0]   s_wb_adr_o,
    output logic [DATA_W-1:0]   s_wb_dat_o,
    input  logic [DATA_W-1:0]   s_wb_dat_i,
    output logic                s_wb_we_o,
    output logic [DATA_W/8-1:0] s_wb_sel_o,
    output logic                s_wb_stb_o,
    input  logic                s_wb_ack_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state;
    logic   last_grant;
    logic   g0;
    logic   g1;
    logic   stb_sel;
    logic   timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign g0      = (state == GNT0);
    assign g1      = (state == GNT1);
    assign stb_sel = (g0 & m0_wb_stb_i) | (g1 & m1_wb_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic [CNT_W-1:0] cnt;

    // An ack arriving on the limit cycle wins over the timeout
    assign timeout = (g0 | g1) & ~s_wb_ack_i
                   & (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        s_wb_we_o  = 1'b0;
        s_wb_sel_o = '0;
        if (g0) begin
            s_wb_adr_o = m0_wb_adr_i;
            s_wb_dat_o = m0_wb_dat_i;
            s_wb_we_o  = m0_wb_we_i;
            s_wb_sel_o = m0_wb_sel_i;
        end else if (g1) begin
            s_wb_adr_o = m1_wb_adr_i;
            s_wb_dat_o = m1_wb_dat_i;
            s_wb_we_o  = m1_wb_we_i;
            s_wb_sel_o = m1_wb_sel_i;
        end
    end

    assign s_wb_stb_o  = stb_sel & ~timeout;
    assign m0_wb_ack_o = g0 & s_wb_ack_i;
    assign m1_wb_ack_o = g1 & s_wb_ack_i;
    assign m0_wb_err_o = g0 & timeout;
    assign m1_wb_err_o = g1 & timeout;
    assign m0_wb_dat_o = g0 ? s_wb_dat_i : '0;
    assign m1_wb_dat_o = g1 ? s_wb_dat_i : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // On a tie the master that did not own the last grant wins
                    if (m0_wb_stb_i && (!m1_wb_stb_i || last_grant)) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                    end else if (m1_wb_stb_i) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (s_wb_ack_i || !stb_sel || timeout)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            if (state == IDLE)
                cnt <= '0;
            else if (!s_wb_ack_i)
                cnt <= cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus random traffic
// checked cycle by cycle against a rule-level ownership model.
module tb_wb_arbiter_2m;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic [1:0]  we;
    logic [3:0]  sel [2];
    logic [1:0]  stb;
    logic [1:0]  ack_o;
    logic [1:0]  err_o;
    logic [31:0] s_adr;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_we;
    logic [3:0]  s_sel;
    logic        s_stb;
    logic        s_ack;

    int checks = 0;
    int errors = 0;

    // reference model: who owns the bus, who owned it last, cycles waited
    int own  = -1;
    int last = 1;
    int wt   = 0;
    logic to_now;
    logic [1:0] done;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_wb_adr_i(adr[0]), .m0_wb_dat_i(wdat[0]), .m0_wb_dat_o(rdat[0]),
        .m0_wb_we_i(we[0]), .m0_wb_sel_i(sel[0]), .m0_wb_stb_i(stb[0]),
        .m0_wb_ack_o(ack_o[0]), .m0_wb_err_o(err_o[0]),
        .m1_wb_adr_i(adr[1]), .m1_wb_dat_i(wdat[1]), .m1_wb_dat_o(rdat[1]),
        .m1_wb_we_i(we[1]), .m1_wb_sel_i(sel[1]), .m1_wb_stb_i(stb[1]),
        .m1_wb_ack_o(ack_o[1]), .m1_wb_err_o(err_o[1]),
        .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat_o), .s_wb_dat_i(s_dat_i),
        .s_wb_we_o(s_we), .s_wb_sel_o(s_sel), .s_wb_stb_o(s_stb),
        .s_wb_ack_i(s_ack)
    );

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // compare every output against the model, away from the clock edge
    task automatic eval();
        logic [31:0] ea, ed;
        logic        ew, es;
        logic [3:0]  esel;
        @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
        to_now = (own >= 0) && (wt == TO) && !s_ack;
`else
        to_now = 1'b0;
`endif
        ea = '0; ed = '0; ew = 1'b0; esel = '0; es = 1'b0;
        if (own >= 0) begin
            ea = adr[own]; ed = wdat[own]; ew = we[own];
            esel = sel[own]; es = stb[own] & ~to_now;
        end
        chk("s_stb", s_stb, es);
        chk("s_adr", s_adr, ea);
        chk("s_dat", s_dat_o, ed);
        chk("s_we", s_we, ew);
        chk("s_sel", s_sel, esel);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_ack", i), ack_o[i], (own == i) && s_ack);
            chk($sformatf("m%0d_err", i), err_o[i], (own == i) && to_now);
            chk($sformatf("m%0d_dat", i), rdat[i],
                (own == i) ? s_dat_i : 32'h0);
            done[i] = ack_o[i] | err_o[i];
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            own = -1; last = 1; wt = 0;
        end else if (own < 0) begin
            if (stb[0] && (!stb[1] || last == 1)) own = 0;
            else if (stb[1]) own = 1;
            if (own >= 0) begin
                last = own; wt = 0;
            end
        end else if (s_ack || !stb[own] || to_now) begin
            own = -1;
        end else begin
            wt++;
        end
        #1;
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adv();
        rst = 1'b0;
    endtask

    initial begin : main
        int order[$];
        int lowrun;
        bit seen_hi;
        logic nack;
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; wdat[i] = '0; sel[i] = '0;
        end
        we = '0; stb = '0; s_ack = 1'b0; s_dat_i = 32'hDEAD_BEEF;
        do_reset();

        // reset state
        eval();
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_acks", ack_o, 2'b00);
        adv();

        // single m0 write, slave acks two cycles after s_stb
        adr[0] = 32'h9000_0004; wdat[0] = 32'h0000_00A5;
        sel[0] = 4'hF; we[0] = 1'b1; stb[0] = 1'b1;
        eval();
        chk("t1_lat0", s_stb, 1'b0);
        adv();
        eval();
        chk("t1_rise", s_stb, 1'b1);
        chk("t1_adr", s_adr, 32'h9000_0004);
        chk("t1_dat", s_dat_o, 32'h0000_00A5);
        adv();
        cyc();
        s_ack = 1'b1;
        eval();
        chk("t1_ack", ack_o, 2'b01);
        adv();
        stb[0] = 1'b0; s_ack = 1'b0;
        eval();
        chk("t1_idle", s_stb, 1'b0);
        adv();

        // both request right after reset, m1 read
        do_reset();
        we[1] = 1'b0; adr[1] = 32'h9000_0010; sel[1] = 4'hF;
        stb = 2'b11;
        cyc();
        cyc();
        s_ack = 1'b1;
        eval();
        chk("t2_m0_first", ack_o, 2'b01);
        adv();
        stb[0] = 1'b0; s_ack = 1'b0;
        cyc();
        s_ack = 1'b1; s_dat_i = 32'h1234_5678;
        eval();
        chk("t2_m1_dat", rdat[1], 32'h1234_5678);
        chk("t2_m0_dat", rdat[0], 32'h0);
        chk("t2_m1_ack", ack_o, 2'b10);
        adv();
        stb = 2'b00; s_ack = 1'b0;
        cyc();

        // sustained contention, slave ack latency 1
        do_reset();
        stb = 2'b11; lowrun = 0; seen_hi = 0;
        for (int n = 0; n < 100 && order.size() < 6; n++) begin
            eval();
            if (ack_o[0]) order.push_back(0);
            if (ack_o[1]) order.push_back(1);
            if (!s_stb) lowrun++;
            else begin
                if (seen_hi && lowrun > 0) chk("t3_gap", lowrun, 1);
                lowrun = 0; seen_hi = 1;
            end
            nack = s_stb & ~s_ack;
            adv();
            s_ack = nack;
        end
        chk("t3_count", order.size(), 6);
        foreach (order[k]) chk($sformatf("t3_order%0d", k), order[k], k % 2);
        stb = 2'b00; s_ack = 1'b0;
        cyc();

        // m1 aborts, pending m0 takes over
        do_reset();
        stb[1] = 1'b1;
        cyc();
        stb[0] = 1'b1;
        cyc();
        cyc();
        stb[1] = 1'b0;
        eval();
        chk("t4_no_ack", ack_o, 2'b00);
        chk("t4_no_err", err_o, 2'b00);
        adv();
        cyc();
        eval();
        chk("t4_m0_gnt", s_adr, adr[0]);
        adv();
        s_ack = 1'b1;
        cyc();
        stb = 2'b00; s_ack = 1'b0;
        cyc();

        // reset while GNT0 waits, then a late ack
        stb[0] = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; s_ack = 1'b1;
        eval();
        chk("t5_s_stb", s_stb, 1'b0);
        chk("t5_late_ack", ack_o, 2'b00);
        adv();
        stb = 2'b00; s_ack = 1'b0;
        cyc();
        cyc();

`ifdef WB_ARB_TIMEOUT_EN
        // stuck slave: err on the 8th cycle after s_stb rose
        do_reset();
        stb[0] = 1'b1;
        cyc();
        for (int k = 0; k < TO; k++) begin
            eval();
            chk("t6_wait_stb", s_stb, 1'b1);
            chk("t6_wait_err", err_o[0], 1'b0);
            adv();
        end
        eval();
        chk("t6_err", err_o, 2'b01);
        chk("t6_stb_off", s_stb, 1'b0);
        adv();
        stb[0] = 1'b0;
        cyc();
        // ack exactly on the limit cycle wins
        stb[0] = 1'b1;
        cyc();
        for (int k = 0; k < TO; k++) cyc();
        s_ack = 1'b1;
        eval();
        chk("t7_ack", ack_o[0], 1'b1);
        chk("t7_no_err", err_o[0], 1'b0);
        adv();
        stb = 2'b00; s_ack = 1'b0;
        cyc();
`endif

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            eval();
            adv();
            rst = ($urandom_range(0, 199) == 0);
            s_ack = ($urandom_range(0, 99) < 35);
            s_dat_i = $urandom;
            for (int i = 0; i < 2; i++) begin
                if (stb[i] && done[i]) stb[i] = 1'b0;
                else if (stb[i] && $urandom_range(0, 99) < 2) stb[i] = 1'b0;
                if (!stb[i] && $urandom_range(0, 99) < 45) begin
                    stb[i] = 1'b1;
                    adr[i] = $urandom; wdat[i] = $urandom;
                    we[i] = 1'($urandom); sel[i] = 4'($urandom);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master Wishbone (classic, stb/ack) arbiter that shares the single audio peripheral slave bus between the CPU external bus (master 0) and a planned audio DMA engine (master 1). It sits between neorv32_wrap/DMA and neo_audio. It uses round-robin arbitration with a registered grant and one-transaction-per-grant sequencing, so the slave is never driven by two masters.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for slave ack before forced termination (used only with WB_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
m0_wb_adr_i / m1_wb_adr_i  in  ADDR_W  master address
m0_wb_dat_i / m1_wb_dat_i  in  DATA_W  master write data
m0_wb_dat_o / m1_wb_dat_o  out  DATA_W  read data to master
m0_wb_we_i / m1_wb_we_i  in  1  write enable
m0_wb_sel_i / m1_wb_sel_i  in  DATA_W/8  byte select
m0_wb_stb_i / m1_wb_stb_i  in  1  request; held until ack/err
m0_wb_ack_o / m1_wb_ack_o  out  1  transfer done
m0_wb_err_o / m1_wb_err_o  out  1  transfer terminated by timeout
s_wb_adr_o  out  ADDR_W  to slave
s_wb_dat_o  out  DATA_W  write data to slave
s_wb_dat_i  in  DATA_W  read data from slave
s_wb_we_o  out  1
s_wb_sel_o  out  DATA_W/8
s_wb_stb_o  out  1
s_wb_ack_i  in  1

Behaviour:
- Reset values: state=IDLE, last_grant=1 (so m0 wins the first tie), timeout counter=0; all s_wb_* outputs 0; all mX_wb_ack_o/err_o/dat_o 0.
- States: IDLE, GNT0, GNT1.
- IDLE: if only m0_stb -> GNT0; only m1_stb -> GNT1; both -> grant the master not equal to last_grant. On entry to GNTx, last_grant<=x. No requests -> stay IDLE.
- Arbitration latency: 1 cycle. s_wb_stb_o first asserts in the cycle after the IDLE cycle that sampled the request.
- GNTx, combinational path: s_wb_adr/dat/we/sel/stb_o = granted master's signals. s_wb_stb_o = mx_stb_i. mx_wb_ack_o = s_wb_ack_i. mx_wb_dat_o = s_wb_dat_i.
- Non-granted master: ack=0, err=0, dat_o=0. Its stb is ignored and left pending.
- Outside GNTx, all s_wb_* outputs are 0.
- GNTx exit: s_wb_ack_i=1 -> IDLE next cycle. Exactly one transfer per grant; one mandatory IDLE turnaround cycle between transfers, even for the same master.
- Abort: mx_stb_i drops in GNTx without ack -> IDLE next cycle, no ack or err generated.
- s_wb_ack_i in IDLE is ignored and not forwarded.
- Simultaneous ack and stb-drop in the same cycle: the ack is forwarded and the state returns to IDLE.
- Sustained contention: masters alternate strictly (m0,m1,m0,...). Neither master waits more than one foreign transfer.
- rst mid-transfer: next cycle is IDLE, all outputs reset. The slave sees stb fall and the transfer is dropped silently.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Defined: an 8+ bit counter (width = clog2(TIMEOUT_CYCLES+1)) clears on GNTx entry and increments each GNTx cycle without ack. When it reaches TIMEOUT_CYCLES without ack:
  - mx_wb_err_o=1 for exactly that one cycle, with ack=0;
  - s_wb_stb_o forced 0 in that cycle;
  - state -> IDLE.
  - Ack in the same cycle the count is reached takes priority: ack forwarded, no err.
- Undefined: no counter is present, err outputs are tied 0, and a stuck slave holds the grant indefinitely.

Test Plan:
- m0 write adr=0x9000_0004, dat=0x0000_00A5, sel=0xF; slave acks 2 cycles after s_stb -> s_stb rises 1 cycle after m0_stb; s_adr/dat match; m0_ack pulses 1 cycle; m1_ack stays 0; IDLE 1 cycle later.
- Both stb asserted the cycle after reset -> m0 served first; m1 granted after m0 ack plus 1 IDLE cycle; m1 read returns slave dat 0x1234_5678 on m1_wb_dat_o, while m0_wb_dat_o reads 0.
- Both masters hold stb for 6 transfers with slave ack latency 1 -> grant order m0,m1,m0,m1,m0,m1; s_stb low exactly 1 cycle between transfers.
- m1 granted, drops stb after 2 cycles with no ack -> no ack or err on m1; pending m0 granted next.
- rst asserted while GNT0 is waiting for ack -> next cycle all outputs 0 and state IDLE; a late s_ack in IDLE is not forwarded.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m0_err high for 1 cycle, 8 cycles after s_stb rise, then IDLE. Separately, ack arriving exactly on cycle 8 -> ack forwarded, err stays 0.
